mac_accumulator: RTL
====================

Name: mac_accumulator

Overview:
- Dot-product stage built around the combinational unsigned_parallel_multiplier.
- Accepts a stream of unsigned operand pairs (x, y) over a valid/ready handshake and feeds each pair to the multiplier.
- Accumulates the products into a running sum and presents the sum once N pairs have been taken, or earlier if a pair is marked last.
- Sits directly downstream of the multiplier and consumes its product every accepted beat.

Parameters:
- W, 4, operand width in bits; must match the W of the multiplier instance.
- N, 4, maximum number of terms per dot product; N >= 2.
- CW, $clog2(N+1), width of the term counter (derived; not overridden).
- AW, 2*W + $clog2(N), accumulator width (derived); overflow is impossible by construction.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  x, y and in_last are valid this cycle.
- in_ready  output  1  block accepts a pair this cycle.
- x  input  W  unsigned multiplicand.
- y  input  W  unsigned multiplier.
- in_last  input  1  this pair is the final term of the current sum.
- out_valid  output  1  acc and count hold a completed sum.
- out_ready  input  1  downstream takes the result.
- acc  output  AW  accumulated sum of x*y.
- count  output  CW  number of terms in acc.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values: state=ACC, acc=0, count=0, out_valid=0.
- in_ready is 0 while rst is high and becomes 1 the first cycle after rst deasserts.
- States:
  - ACC: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Input accept: occurs when in_valid && in_ready.
  - On accept, acc <= acc + zero-extended p (p = x*y from the multiplier, 2W bits) and count <= count+1, in the same edge.
  - The multiplier is purely combinational, so there is no added latency.
- ACC -> DONE transition: on an accept where in_last=1 or count+1==N. acc and count then hold the final values, and out_valid=1 on the next cycle.
  - Latency: out_valid rises exactly one cycle after the final accepted beat.
- DONE -> ACC transition: when out_ready=1 (out_valid is 1 in DONE). On that edge acc<=0 and count<=0.
  - No input is accepted in DONE, so there is one bubble cycle per result.
- Backpressure: while in DONE with out_ready=0, acc, count and out_valid hold steady indefinitely. in_valid is ignored and no input is consumed.
- in_valid=0 in ACC: no state change; gaps between beats are allowed at any length.
- in_last on the N-th beat: same as a normal terminating beat; count=N.
- in_last while not accepted (in_valid=0 or in DONE): ignored.
- Reset mid-operation, in ACC or DONE: discards the partial or pending sum. Outputs take reset values the next cycle; no stale out_valid.
- rst has priority over any simultaneous handshake.
- count never exceeds N; acc never wraps (max N*(2^W-1)^2 < 2^AW).

Decomposition:
- Shared package (mac_pkg): 1-bit state enum {ACC, DONE}; helper functions for AW and CW in terms of W and N.
- Sub-module: one instance of unsigned_parallel_multiplier #(.W(W)) with ports .x, .y, .p.
  - Its output p (2W bits) is the only product source; no other arithmetic sub-module.

Test Plan (W=4, N=4):
- Reset: hold rst 2 cycles with in_valid=1 -> in_ready=0 during reset, acc=0, count=0, out_valid=0; in_ready=1 the cycle after release.
- Full sum: pairs (2,4),(15,3),(15,15),(1,1) on consecutive cycles with out_ready=1 -> out_valid one cycle after the 4th accept with acc=279, count=4; acc=0 the cycle after the handshake.
- Max value: four (15,15) beats -> acc=900, count=4, fits in AW=10 bits, no wrap.
- Early termination: (3,5), then (7,7) with in_last=1 -> out_valid with acc=64, count=2; the next sum starts from 0.
- Backpressure: complete the 279 sum, hold out_ready=0 for 5 cycles while driving in_valid=1 with (9,9) -> acc stays 279, in_ready=0, (9,9) not consumed; after out_ready=1, (9,9) is accepted in ACC and contributes 81 to the next sum.
- Gaps plus reset mid-sum: (2,2), idle 3 cycles, (3,3), then rst for 1 cycle -> acc=0, count=0. Then (1,2),(1,2),(1,2),(1,2) -> acc=8, count=4 (pre-reset terms excluded).

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and width helpers for the multiply-accumulate stage.
package mac_pkg;

    // ACC: taking operand pairs; DONE: holding a finished sum for downstream.
    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } mac_state_t;

    // Accumulator width: a 2W-bit product summed up to N times never overflows.
    function automatic int unsigned mac_acc_width(input int unsigned w, input int unsigned n);
        return 2 * w + $clog2(n);
    endfunction

    // Term counter width: must be able to hold the value N itself.
    function automatic int unsigned mac_cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/unsigned_parallel_multiplier.sv
// Combinational unsigned W x W multiplier producing a full 2W-bit product.
module unsigned_parallel_multiplier #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic [2*W-1:0] p
);

    logic [2*W-1:0] y_ext;

    assign y_ext = {{W{1'b0}}, y};

    // Sum of shifted partial products, one per set bit of x.
    always_comb begin
        p = '0;
        for (int i = 0; i < W; i++) begin
            if (x[i]) begin
                p = p + (y_ext << i);
            end
        end
    end

endmodule

// File: rtl/mac_accumulator.sv
// Dot-product stage: multiplies each accepted (x, y) pair and accumulates the
// products until N terms have been taken or a pair is flagged last, then holds
// the sum until downstream takes it.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int unsigned W  = 4,
    parameter int unsigned N  = 4,
    parameter int unsigned CW = mac_cnt_width(N),
    parameter int unsigned AW = mac_acc_width(W, N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  x,
    input  logic [W-1:0]  y,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] acc,
    output logic [CW-1:0] count
);

    mac_state_t     state_q, state_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  count_q, count_d;

    logic [2*W-1:0] p;
    logic [AW-1:0]  p_ext;
    logic [CW-1:0]  count_inc;
    logic           accept;
    logic           final_beat;

    unsigned_parallel_multiplier #(
        .W (W)
    ) u_mult (
        .x (x),
        .y (y),
        .p (p)
    );

    assign p_ext      = {{(AW - 2 * W){1'b0}}, p};
    assign count_inc  = count_q + CW'(1);
    // Readiness is gated by rst so nothing looks acceptable while resetting.
    assign in_ready   = (state_q == ACC) && !rst;
    assign accept     = in_valid && in_ready;
    assign final_beat = in_last || (count_inc == CW'(N));

    assign out_valid  = (state_q == DONE);
    assign acc        = acc_q;
    assign count      = count_q;

    // Next-state: accumulate on accept, clear the sum once it is handed off.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        unique case (state_q)
            ACC: begin
                if (accept) begin
                    acc_d   = acc_q + p_ext;
                    count_d = count_inc;
                    if (final_beat) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = ACC;
                    acc_d   = '0;
                    count_d = '0;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC;
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

endmodule
